// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU family.
//   DEF_WIDTH      default operand width
//   OP_*           3-bit opcode encodings (opCodeA)
//   state_t        execution-unit FSM states
package alu_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_MUL_RUN = 2'd1,
    S_DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/alu_if.sv
// Command/result bus between a command issuer/consumer and alu_exec_unit.
//   master : issuer side - drives in_valid, A, B, CarryIN, opCodeA, out_ready
//   slave  : execution unit - drives in_ready, out_valid, Y, CarryOUT,
//            overflow, illegal, done_count
interface alu_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = 16
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic               CarryIN;
  logic [2:0]         opCodeA;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] Y;
  logic               CarryOUT;
  logic               overflow;
  logic               illegal;
  logic [CNT_W-1:0]   done_count;

  modport master (
    output in_valid, A, B, CarryIN, opCodeA, out_ready,
    input  in_ready, out_valid, Y, CarryOUT, overflow, illegal, done_count
  );

  modport slave (
    input  in_valid, A, B, CarryIN, opCodeA, out_ready,
    output in_ready, out_valid, Y, CarryOUT, overflow, illegal, done_count
  );

endinterface

// File: rtl/alu_comb.sv
// Combinational ALU datapath for every single-cycle opcode
// (ADD/SUB/AND/OR/XOR/SHL/reserved). MUL yields zeros here; the iterative
// multiplier lives in alu_exec_unit.
//   a_i, b_i   operands
//   cin_i      carry in (ADD/SUB)
//   op_i       opcode
//   y_o        2*WIDTH-bit result
//   cout_o     carry out of bit WIDTH-1
//   ovf_o      signed overflow (ADD/SUB)
//   illegal_o  reserved opcode
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               cin_i,
  input  logic [2:0]         op_i,
  output logic [2*WIDTH-1:0] y_o,
  output logic               cout_o,
  output logic               ovf_o,
  output logic               illegal_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;

  // SUB reuses the adder with B inverted; CarryIN=1 supplies the +1.
  always_comb begin
    b_eff = (op_i == OP_SUB) ? ~b_i : b_i;
    sum   = {1'b0, a_i} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_i};
  end

  always_comb begin
    y_o       = '0;
    cout_o    = 1'b0;
    ovf_o     = 1'b0;
    illegal_o = 1'b0;
    case (op_i)
      OP_ADD, OP_SUB: begin
        y_o    = {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
        cout_o = sum[WIDTH];
        ovf_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) &&
                 (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: y_o = {{WIDTH{1'b0}}, a_i & b_i};
      OP_OR:  y_o = {{WIDTH{1'b0}}, a_i | b_i};
      OP_XOR: y_o = {{WIDTH{1'b0}}, a_i ^ b_i};
      OP_SHL: y_o = {{WIDTH{1'b0}}, a_i} << b_i[1:0];
      OP_RSV: illegal_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential execution front-end for the ALU. Accepts one command per
// valid/ready handshake, executes single-cycle ops through alu_comb and
// MUL as WIDTH shift-add iterations, and holds each result in a one-entry
// buffer until the consumer takes it.
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus        alu_if slave: command in, result out, done_count
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IT = IW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;
  logic               ov_q, ov_d;
  logic [CNT_W-1:0]   done_q, done_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [IW-1:0]      it_q, it_d;

  logic [2*WIDTH-1:0] c_y;
  logic               c_cout, c_ovf, c_ill;
  logic [2*WIDTH-1:0] mul_sum;
  logic               in_ready, take, accept;

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .a_i      (bus.A),
    .b_i      (bus.B),
    .cin_i    (bus.CarryIN),
    .op_i     (bus.opCodeA),
    .y_o      (c_y),
    .cout_o   (c_cout),
    .ovf_o    (c_ovf),
    .illegal_o(c_ill)
  );

  // DONE also accepts when its result is taken on the same edge, so a
  // command can follow a result without an IDLE bubble. In IDLE the buffer
  // is always empty, so the out_ready term only matters in DONE.
  always_comb begin
    take     = ov_q && bus.out_ready;
    in_ready = !rst && (state_q != S_MUL_RUN) && (!ov_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;
    mul_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    ov_d     = ov_q;
    done_d   = done_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    it_d     = it_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (take) begin
          ov_d    = 1'b0;
          done_d  = done_q + 1'b1;
          state_d = S_IDLE;
        end
        if (accept) begin
          if (bus.opCodeA == OP_MUL) begin
            state_d  = S_MUL_RUN;
            it_d     = '0;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, bus.A};
            mplier_d = bus.B;
          end else begin
            y_d     = c_y;
            cout_d  = c_cout;
            ovf_d   = c_ovf;
            ill_d   = c_ill;
            ov_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_MUL_RUN: begin
        acc_d    = mul_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        it_d     = it_q + 1'b1;
        if (it_q == LAST_IT) begin
          y_d     = mul_sum;
          cout_d  = 1'b0;
          ovf_d   = |mul_sum[2*WIDTH-1:WIDTH];
          ill_d   = 1'b0;
          ov_d    = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      y_q      <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      ov_q     <= 1'b0;
      done_q   <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      it_q     <= '0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      ov_q     <= ov_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      it_q     <= it_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = ov_q;
  assign bus.Y          = y_q;
  assign bus.CarryOUT   = cout_q;
  assign bus.overflow   = ovf_q;
  assign bus.illegal    = ill_q;
  assign bus.done_count = done_q;

endmodule
